fetch_controller: RTL and testbench

Instruction-fetch sequencer for the soft processor. It drives the word-index PC into the synchronous-read instruction memory and absorbs that memory's one-cycle read latency. Fetched words go through a 2-entry output buffer with a valid/ready handshake toward decode. The block also handles start, PC redirect, program-end detection (all-zero word) and address-range faults.

---
 rtl/fetch_controller.sv | 133 +++++++++++++
 tb/tb_fetch_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Brief    : Instruction-fetch sequencer for a 1-cycle synchronous-read memory,
//            with a 2-entry valid/ready output buffer toward decode.
// Revision : 1.0
// ============================================================================
module fetch_controller #(
    parameter int unsigned ADDR_LIMIT   = 128,
    parameter int unsigned START_PC     = 0,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        busy,
    output logic        halted,
    output logic        err_range
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_FETCH = 2'd1;
    localparam logic [1:0]  c_ST_DRAIN = 2'd2;
    localparam logic [1:0]  c_ST_HALT  = 2'd3;
    localparam logic [31:0] c_LIMIT    = 32'(ADDR_LIMIT);
    localparam logic [31:0] c_START    = 32'(START_PC);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_mem_pc;
    logic        r_rd_pend;
    logic [31:0] r_pend_pc;
    logic [31:0] r_buf_inst [2];
    logic [31:0] r_buf_pc   [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;
    logic        r_err;

    logic        w_fetch;
    logic        w_pop;
    logic [2:0]  w_occ;
    logic        w_space;
    logic        w_in_range;
    logic        w_issue;
    logic        w_fault;
    logic        w_zero;
    logic        w_push;
    logic        w_redir;
    logic        w_start;

    always_comb begin
        w_fetch    = (r_state == c_ST_FETCH);
        w_pop      = (r_cnt != 2'd0) && out_ready;
        // Occupancy the buffer will have once the in-flight read lands.
        w_occ      = {1'b0, r_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
        w_space    = (w_occ <= 3'd1);
        w_in_range = (r_mem_pc < c_LIMIT);
        w_issue    = w_fetch && w_space && w_in_range;
        w_fault    = w_fetch && !w_in_range;
        w_zero     = HALT_ON_ZERO && w_fetch && r_rd_pend && (mem_inst == 32'd0);
        w_push     = w_fetch && r_rd_pend && !w_zero;
        w_redir    = redirect && ((r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN));
        w_start    = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_HALT));

        w_state_nxt = r_state;
        case (r_state)
            c_ST_FETCH: if (w_fault || w_zero) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (r_cnt == 2'd0) w_state_nxt = c_ST_HALT;
            default:    w_state_nxt = r_state;
        endcase
        if (w_redir || w_start) w_state_nxt = c_ST_FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_mem_pc  <= c_START;
            r_rd_pend <= 1'b0;
            r_pend_pc <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_cnt     <= 2'd0;
            r_err     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_inst[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_start || w_redir) begin
                r_mem_pc  <= w_start ? c_START : redirect_pc;
                r_rd_pend <= 1'b0;
                r_wr_ptr  <= 1'b0;
                r_rd_ptr  <= 1'b0;
                r_cnt     <= 2'd0;
                if (w_start) r_err <= 1'b0;
            end else begin
                r_rd_pend <= w_issue;
                if (w_issue) begin
                    r_mem_pc  <= r_mem_pc + 32'd1;
                    r_pend_pc <= r_mem_pc;
                end
                if (w_fault) r_err <= 1'b1;
                if (w_push) begin
                    r_buf_inst[r_wr_ptr] <= mem_inst;
                    r_buf_pc[r_wr_ptr]   <= r_pend_pc;
                    r_wr_ptr             <= ~r_wr_ptr;
                end
                if (w_pop) r_rd_ptr <= ~r_rd_ptr;
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    assign mem_pc    = r_mem_pc;
    assign out_valid = (r_cnt != 2'd0);
    assign out_inst  = r_buf_inst[r_rd_ptr];
    assign out_pc    = r_buf_pc[r_rd_ptr];
    assign busy      = (r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN);
    assign halted    = (r_state == c_ST_HALT);
    assign err_range = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Brief    : Self-checking bench; two instances (halt-on-zero at pc 0, and
//            pass-zero starting at pc 126) against a word-sequence model.
// Revision : 1.0
// ============================================================================
module tb_fetch_controller;

    localparam int c_LIMIT = 128;

    logic             clk;
    logic             rst;
    logic [1:0]       start;
    logic [1:0]       redirect;
    logic [1:0]       out_ready;
    logic [1:0][31:0] redirect_pc;
    logic [1:0][31:0] mem_inst;
    wire  [1:0]       out_valid;
    wire  [1:0]       busy;
    wire  [1:0]       halted;
    wire  [1:0]       err_range;
    wire  [1:0][31:0] mem_pc;
    wire  [1:0][31:0] out_inst;
    wire  [1:0][31:0] out_pc;

    logic [31:0] mem [2][c_LIMIT];
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    logic [1:0]  hold;
    logic [31:0] hold_pc   [2];
    logic [31:0] hold_inst [2];
    int          n_cmp;
    int          n_mis;

    fetch_controller u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .mem_pc(mem_pc[0]),
        .mem_inst(mem_inst[0]), .redirect(redirect[0]), .redirect_pc(redirect_pc[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_inst(out_inst[0]),
        .out_pc(out_pc[0]), .busy(busy[0]), .halted(halted[0]), .err_range(err_range[0])
    );

    fetch_controller #(.ADDR_LIMIT(128), .START_PC(126), .HALT_ON_ZERO(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .mem_pc(mem_pc[1]),
        .mem_inst(mem_inst[1]), .redirect(redirect[1]), .redirect_pc(redirect_pc[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_inst(out_inst[1]),
        .out_pc(out_pc[1]), .busy(busy[1]), .halted(halted[1]), .err_range(err_range[1])
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memories, one per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            mem_inst[d] <= (mem_pc[d] < 32'(c_LIMIT)) ? mem[d][mem_pc[d][6:0]] : 32'hA5A5_5A5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [31:0] head_pc(input int d);
        logic [63:0] e;
        e = (d == 0) ? exp_q0[0] : exp_q1[0];
        return e[63:32];
    endfunction

    task automatic fill(input int d, input int zero_at);
        for (int i = 0; i < c_LIMIT; i++)
            mem[d][i] = (i == zero_at) ? 32'd0 : ($urandom() | 32'h0000_0001);
    endtask

    // Words the consumer should see from pc0 on: consecutive words until the
    // address limit, or until a zero word on the halt-on-zero instance.
    task automatic build(input int d, input int pc0);
        logic [63:0] e;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
        for (int pc = pc0; pc < c_LIMIT; pc++) begin
            if (d == 0 && mem[d][pc] == 32'd0) break;
            e = {32'(pc), mem[d][pc]};
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        for (int d = 0; d < 2; d++) begin
            if (hold[d]) begin
                chk("hold_valid", 32'(out_valid[d]), 32'd1);
                chk("hold_pc", out_pc[d], hold_pc[d]);
                chk("hold_inst", out_inst[d], hold_inst[d]);
            end
            if (out_valid[d] && out_ready[d]) begin
                chk("pop_expected", 32'(qsize(d) != 0), 32'd1);
                if (qsize(d) != 0) begin
                    if (d == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                    chk("pop_pc", out_pc[d], e[63:32]);
                    chk("pop_inst", out_inst[d], e[31:0]);
                end
            end
            hold[d]      = out_valid[d] && !out_ready[d] && !redirect[d] && !rst;
            hold_pc[d]   = out_pc[d];
            hold_inst[d] = out_inst[d];
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt(input int d, input int limit, input bit rnd);
        int n;
        n = 0;
        while (!halted[d] && n < limit) begin
            out_ready[d] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            n++;
        end
        chk("halt_reached", 32'(halted[d]), 32'd1);
        chk("queue_drained", 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        logic [31:0] tgt;
        clk = 1'b0; rst = 1'b1; start = '0; redirect = '0; out_ready = '0;
        redirect_pc = '0; n_cmp = 0; n_mis = 0; hold = '0;
        fill(0, -1); fill(1, -1);
        step(); step();

        chk("rst_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_halted", 32'(halted[0]), 32'd0);
        chk("rst_err", 32'(err_range[0]), 32'd0);
        chk("rst_mem_pc", mem_pc[0], 32'd0);
        chk("rst_out_inst", out_inst[0], 32'd0);
        chk("rst_out_pc", out_pc[0], 32'd0);
        chk("rst_mem_pc_b", mem_pc[1], 32'd126);
        rst = 1'b0;
        step();

        // Normal run ending on the zero word at pc 4.
        fill(0, 4); build(0, 0); out_ready[0] = 1'b1;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        chk("run_s1_valid", 32'(out_valid[0]), 32'd0);
        chk("run_s1_busy", 32'(busy[0]), 32'd1);
        step();
        chk("run_s2_valid", 32'(out_valid[0]), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("run_valid", 32'(out_valid[0]), 32'd1);
            chk("run_pc", out_pc[0], 32'(k));
            step();
        end
        chk("run_drain_valid", 32'(out_valid[0]), 32'd0);
        chk("run_drain_busy", 32'(busy[0]), 32'd1);
        chk("run_drain_halted", 32'(halted[0]), 32'd0);
        step();
        chk("run_halted", 32'(halted[0]), 32'd1);
        chk("run_halt_busy", 32'(busy[0]), 32'd0);
        chk("run_queue", 32'(qsize(0)), 32'd0);

        // Random consumer, then a 5-cycle stall mid-stream.
        fill(0, 60); build(0, 0); out_ready[0] = 1'b1;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            out_ready[0] = ($urandom_range(0, 3) != 0); step();
        end
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 5; i++) begin
            out_ready[0] = 1'b0;
            if (i >= 3) begin
                chk("bp_valid", 32'(out_valid[0]), 32'd1);
                chk("bp_mem_pc", mem_pc[0], head_pc(0) + 32'd2);
            end
            step();
        end
        gap = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready[0] = 1'b1;
            if (!out_valid[0]) gap++; else gap = 0;
            chk("bp_no_bubble", 32'(gap <= 1), 32'd1);
            step();
        end
        run_to_halt(0, 300, 1'b1);
        chk("bp_err", 32'(err_range[0]), 32'd0);

        // Redirect while streaming at pc 5, then random redirects.
        fill(0, 100); build(0, 0); out_ready[0] = 1'b1;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        n = 0;
        while (!(out_valid[0] && out_pc[0] == 32'd5) && n < 20) begin step(); n++; end
        chk("rd_at5", out_pc[0], 32'd5);
        tgt = 32'd10;
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                n = $urandom_range(3, 12);
                for (int i = 0; i < n; i++) begin
                    out_ready[0] = ($urandom_range(0, 3) != 0); step();
                end
                tgt = $urandom_range(0, 70);
            end
            redirect[0] = 1'b1; redirect_pc[0] = tgt; step(); redirect[0] = 1'b0;
            build(0, int'(tgt));
            chk("rd_m1_valid", 32'(out_valid[0]), 32'd0);
            step();
            chk("rd_m2_valid", 32'(out_valid[0]), 32'd0);
            step();
            chk("rd_m3_valid", 32'(out_valid[0]), 32'd1);
            chk("rd_m3_pc", out_pc[0], tgt);
        end
        run_to_halt(0, 400, 1'b1);

        // Reset with two entries buffered.
        fill(0, 20); build(0, 0); out_ready[0] = 1'b1;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        for (int i = 0; i < 6; i++) step();
        out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mrst_full", mem_pc[0], head_pc(0) + 32'd2);
        rst = 1'b1; step(); rst = 1'b0;
        exp_q0.delete(); exp_q1.delete();
        chk("mrst_valid", 32'(out_valid[0]), 32'd0);
        chk("mrst_busy", 32'(busy[0]), 32'd0);
        chk("mrst_halted", 32'(halted[0]), 32'd0);
        chk("mrst_mem_pc", mem_pc[0], 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("mrst_idle_busy", 32'(busy[0]), 32'd0);
        chk("mrst_idle_valid", 32'(out_valid[0]), 32'd0);
        build(0, 0); out_ready[0] = 1'b1;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        run_to_halt(0, 200, 1'b1);

        // Range fault on the instance starting at pc 126.
        fill(1, 2); build(1, 126); out_ready[1] = 1'b1;
        start[1] = 1'b1; step(); start[1] = 1'b0;
        chk("rf_s1_err", 32'(err_range[1]), 32'd0);
        chk("rf_s1_busy", 32'(busy[1]), 32'd1);
        step(); step();
        chk("rf_s3_valid", 32'(out_valid[1]), 32'd1);
        chk("rf_s3_pc", out_pc[1], 32'd126);
        step();
        chk("rf_s4_pc", out_pc[1], 32'd127);
        chk("rf_s4_err", 32'(err_range[1]), 32'd1);
        step();
        chk("rf_s5_valid", 32'(out_valid[1]), 32'd0);
        chk("rf_s5_halted", 32'(halted[1]), 32'd0);
        step();
        chk("rf_s6_halted", 32'(halted[1]), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("rf_mem_pc", mem_pc[1], 32'd128);
        chk("rf_err_sticky", 32'(err_range[1]), 32'd1);
        chk("rf_queue", 32'(qsize(1)), 32'd0);

        // Zero word passed through when halt-on-zero is off.
        start[1] = 1'b1; step(); start[1] = 1'b0;
        chk("nz_err_clear", 32'(err_range[1]), 32'd0);
        redirect[1] = 1'b1; redirect_pc[1] = 32'd0; step(); redirect[1] = 1'b0;
        build(1, 0);
        chk("nz_m1_valid", 32'(out_valid[1]), 32'd0);
        step(); step();
        chk("nz_m3_pc", out_pc[1], 32'd0);
        n = 0;
        while (!(out_valid[1] && out_pc[1] == 32'd2) && n < 10) begin step(); n++; end
        chk("nz_valid", 32'(out_valid[1]), 32'd1);
        chk("nz_pc", out_pc[1], 32'd2);
        chk("nz_inst", out_inst[1], 32'd0);
        run_to_halt(1, 600, 1'b1);
        chk("nz_err", 32'(err_range[1]), 32'd1);
        chk("nz_mem_pc", mem_pc[1], 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
